// File: rtl/mux_41_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux with a dead cycle between grants.
// Optional grant timeout/preemption is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_41_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       Clk_in,
  input  logic       Reset_n_in,
  input  logic [3:0] Req_in,
  output logic [3:0] Grant_out,
  output logic       S0_out,
  output logic       S1_out,
  output logic       Valid_out,
  output logic       Preempt_out
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HANDOFF
  } state_e;

  localparam logic [HOLD_W-1:0] CNT_MAX = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        sel_q, sel_d;
  logic              valid_q, valid_d;

  logic [2:0]        pick;
  logic              others;

  // {found, index}: first requester after 'last', wrapping, 'last' itself ranked last
  function automatic logic [2:0] rr_pick(
    input logic [1:0] last,
    input logic [3:0] req
  );
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign pick   = rr_pick(ptr_q, Req_in);
  assign others = |(Req_in & ~(4'b0001 << ptr_q));

`ifdef MUX_ARB_TIMEOUT_EN
  logic preempt_q, preempt_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
`ifdef MUX_ARB_TIMEOUT_EN
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      IDLE, HANDOFF: begin
        if (pick[2]) begin
          state_d = GRANT;
          grant_d = 4'b0001 << pick[1:0];
          sel_d   = pick[1:0];
          valid_d = 1'b1;
          ptr_d   = pick[1:0];
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          grant_d = 4'b0000;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (!Req_in[ptr_q]) begin
          state_d = HANDOFF;
          grant_d = 4'b0000;
          valid_d = 1'b0;
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_MAX && others) begin
          state_d   = HANDOFF;
          grant_d   = 4'b0000;
          valid_d   = 1'b0;
          preempt_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) preempt_q <= 1'b0;
    else             preempt_q <= preempt_d;
  end
  assign Preempt_out = preempt_q;
`else
  assign Preempt_out = 1'b0;
`endif

  assign Grant_out = grant_q;
  assign S1_out    = sel_q[1];
  assign S0_out    = sel_q[0];
  assign Valid_out = valid_q;

endmodule
